shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier, the inverse-direction companion to the restoring divider in the Diffie-Hellman arithmetic datapath. Accepts two WIDTH-bit operands on a start pulse, produces a 2·WIDTH-bit product after at most WIDTH clock cycles, and signals completion with the same start/ready handshake the divider uses. Used by the modular-exponentiation controller for the square/multiply step that precedes each division-based reduction.

## Interface
- WIDTH, 16, operand width in bits; product is 2·WIDTH bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load operands and begin a multiplication; sampled every rising edge.
- multiplicand  input  WIDTH  unsigned operand A; sampled only on the start edge.
- multiplier  input  WIDTH  unsigned operand B; sampled only on the start edge.
- product  output  2·WIDTH  A·B; holds the last completed result, updated only on the completion edge.
- ready  output  1  high when idle and product is valid; low while busy.
- done  output  1  one-cycle pulse on the cycle ready rises after a computation.

## Operation
- States: IDLE (ready=1) and BUSY (ready=0).
- Reset values: product=0, ready=1, done=0, state IDLE, internal accumulator/counter cleared. rst has priority over start.
- start=1 in any state (including BUSY) loads: acc=0, mcand_sh={WIDTH'b0,A}, mplier_sh=B, bitc=WIDTH, state BUSY, ready=0. A start during BUSY aborts the current operation; product keeps the last completed value.
- Each BUSY cycle without start: if mplier_sh[0], acc=acc+mcand_sh (2·WIDTH-bit add, cannot overflow); mcand_sh<<=1; mplier_sh>>=1; bitc-=1.
- Completion when bitc reaches 0 after the step: product=acc (post-add value), ready=1, done=1, state IDLE.
- done is deasserted on every other cycle; it is never asserted because of reset.
- In IDLE with start=0: no state change; product stable.
- Unsigned only; no signed or saturation handling.

## Timing
- start sampled on edge N; BUSY steps on edges N+1 … N+WIDTH; ready and done high after edge N+WIDTH (latency WIDTH cycles, 16 by default).
- ready low from edge N+1 output onward, i.e. visible low the cycle after start.
- start asserted on the cycle done is high is accepted: new operation begins, product remains the just-completed value until the next completion.
- rst asserted mid-operation: next edge returns to reset values; product cleared to 0.
- Operands may change freely after the start edge.

## Configuration
- SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN defined: completion also occurs on the first BUSY step after which the shifted multiplier is all zeros; latency = max(1, index of highest set bit of B + 1) cycles (B=0 or B=1 → 1 cycle). Product value identical.
- Not defined: latency is always exactly WIDTH cycles regardless of operands (constant-time, required for side-channel-sensitive builds).

## Structure
- Shared package dh_arith_pkg: default WIDTH constant, the IDLE/BUSY state enum, and the counter width constant (clog2(WIDTH+1)), common with the divider.
- No sub-module: one adder, two shift registers, one down-counter and the two-state FSM live in a single module.

## Test plan
- A=3, B=5, start one cycle → ready low next cycle, done pulse and product=0x0000000F exactly 16 cycles after start edge.
- A=0xFFFF, B=0xFFFF → product=0xFFFE0001; A=0, B=0x1234 → product=0.
- Start A=7,B=9; at cycle 5 restart with A=2,B=3 → single done 16 cycles after restart, product=6, never 63; product holds previous value during both runs.
- rst pulsed at cycle 8 of a run → next cycle ready=1, done=0, product=0; no done pulse follows.
- start re-asserted on the done cycle with A=4,B=4 → back-to-back result 16 cycles later, product=16; done high exactly one cycle each time.
- With SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN: A=0x1234,B=1 → done 1 cycle after start, product=0x1234; B=0x0100 → 9 cycles; without macro both take 16 cycles.

Source files
------------

// File: rtl/dh_arith_pkg.sv
// Shared constants and types for the Diffie-Hellman arithmetic datapath.
// Used by both the shift-add multiplier and the restoring divider.
package dh_arith_pkg;

  localparam int DH_WIDTH = 16;
  localparam int DH_CNT_W = $clog2(DH_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dh_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, WIDTH cycles per product.
// SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN: finish once multiplier bits run out.
module shift_add_multiplier
  import dh_arith_pkg::*;
#(
  parameter int WIDTH = DH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic             ready,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  dh_state_e        state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand_sh;
  logic [WIDTH-1:0] mplier_sh;
  logic [CW-1:0]    bitc;

  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_nx;
  logic [CW-1:0]    bitc_nx;
  logic             last;

  // One step of the add/shift datapath and its completion test
  always_comb begin
    acc_sum   = acc;
    if (mplier_sh[0])
      acc_sum = acc + mcand_sh;
    mplier_nx = mplier_sh >> 1;
    bitc_nx   = bitc - CW'(1);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    last = (bitc_nx == '0) || (mplier_nx == '0);
`else
    last = (bitc_nx == '0);
`endif
  end

  // Two-state FSM; start always (re)loads, even mid-operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      bitc      <= '0;
      product   <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state     <= BUSY;
        acc       <= '0;
        mcand_sh  <= {{WIDTH{1'b0}}, multiplicand};
        mplier_sh <= multiplier;
        bitc      <= CW'(WIDTH);
        ready     <= 1'b0;
      end else begin
        unique case (state)
          BUSY: begin
            acc       <= acc_sum;
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_nx;
            bitc      <= bitc_nx;
            if (last) begin
              product <= acc_sum;
              ready   <= 1'b1;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end
          IDLE: begin
          end
        endcase
      end
    end
  end

endmodule
